pen_rr_arb: RTL and testbench
=============================

Name: peN_rr_arb

Overview:
- Multi-grant round-robin arbiter. Each cycle it selects up to N requesters from a WIDTH-bit request vector, scanning from a registered rotating priority pointer with wrap-around.
- Downstream consumes a prefix of the grant slots each cycle through an accept count. The pointer advances past the last consumed grant.
- A mode input selects between round-robin and fixed LSB-first priority.
- Used wherever N issue/dispatch/writeback slots are shared fairly among WIDTH sources.

Parameters:
- WIDTH, 8, number of requesters; must be >= 2; need not be a power of two.
- N, 3, number of grant slots per cycle; 1 <= N <= WIDTH.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- rr_mode  input  1  1 = round-robin from pointer; 0 = fixed priority from index 0.
- req_vec  input  WIDTH  request bits.
- accept_count  input  $clog2(N+1)  number of leading grant slots consumed this cycle.
- ack_valid_by_n  output  N  slot n holds a grant.
- ack_one_hot_by_n  output  N x WIDTH  one-hot grant per slot.
- ack_index_by_n  output  N x $clog2(WIDTH)  binary index of each slot's grant.
- ack_count  output  $clog2(N+1)  number of valid slots, equal to min(popcount(req_vec), N).
- ptr  output  $clog2(WIDTH)  current priority pointer register.

Behaviour:
- State: ptr register only. Reset value is 0.
- Scan order starts at base = (rr_mode ? ptr : 0) and visits base, base+1, ..., WIDTH-1, 0, ..., base-1. Wrap is mod WIDTH, not mod 2^$clog2(WIDTH).
- Slot n is assigned the (n+1)th set bit of req_vec in scan order.
  - ack_valid_by_n[n] = 1 iff popcount(req_vec) >= n+1.
  - Invalid slots drive one-hot 0 and index 0.
- Grant outputs are combinational from req_vec, rr_mode and ptr (zero latency).
- The valid bits form a thermometer: slot n valid implies every slot below n is valid. The one-hot vectors across slots are mutually disjoint.
- Consumption: k_eff = min(accept_count, ack_count). Slots 0..k_eff-1 fire. Accepting a non-prefix set of slots is not expressible.
- ptr update at posedge CLK, in priority order:
  - RST = 1: ptr <= 0.
  - else rr_mode = 0: ptr <= 0.
  - else k_eff = 0: ptr holds.
  - else ptr <= (ack_index_by_n[k_eff-1] + 1) mod WIDTH. When that index is WIDTH-1, the new ptr is 0.
- While RST = 1: ack_valid_by_n, ack_one_hot_by_n, ack_index_by_n and ack_count are forced to 0. ptr shows its register value until the reset edge.
- rr_mode may change any cycle.
  - The 1->0 change takes effect combinationally.
  - After a 0->1 change, scanning starts from ptr = 0, because ptr was held at 0 in fixed mode.
- Fairness: with every requester continuously active and accept_count = N, each requester is granted once per ceil(WIDTH/N)-cycle window or better.
- A requester skipped because it was granted but not accepted keeps its position. Since ptr only passes consumed grants, that requester is slot 0 next cycle.
- Simultaneous RST and accept: RST wins.
- accept_count values above N are clamped like any excess.

Test Plan:
- Reset: RST=1, req_vec=8'hFF, accept_count=3 -> ack_valid_by_n=000, all one-hots 0, ack_count=0. After the edge, ptr=0. Then RST=0 -> grants {2,1,0}.
- Fixed mode: rr_mode=0, req_vec=8'b01011010, accept_count=3 -> one-hots {00010000, 00001000, 00000010}, indices {4,3,1}, valid=111, ack_count=3. ptr stays 0 over repeated cycles.
- Round-robin wrap: rr_mode=1, req_vec=8'hFF, accept_count=3 from ptr=0:
  - cycle 0 grants indices 0,1,2 -> ptr=3;
  - cycle 1 grants 3,4,5 -> ptr=6;
  - cycle 2 grants 6,7,0 -> ptr=1.
- Partial accept: ptr=0, req_vec=8'b10000011, accept_count=1:
  - cycle 0 grants {7,1,0} -> ptr=1;
  - cycle 1 grants slots 1,7,0 in order -> accept 2 -> ptr=0 (index 7 + 1 wraps);
  - with accept_count=0 the ptr holds.
- Clamp and sparse: ptr=3, req_vec=8'b00100000, accept_count=3 -> valid=001, slot 0 = index 5, ack_count=1, ptr -> 6. Non-power-of-two WIDTH=6: ptr=5, req all ones, accept 2 -> grants 5,0; ptr -> 1.
- Reset mid-operation and exhaustive:
  - RST asserted with ptr=5 and accept_count=3 -> outputs 0, ptr=0 next cycle.
  - Exhaustive sweep over all 256 req_vec x all 8 ptr values x accept_count 0..3 x rr_mode, compared against a scan-order reference model for the grant outputs and next ptr.

Source files
------------

// File: rtl/pen_rr_arb.sv
// Multi-grant round-robin arbiter: up to N grants per cycle, scanned from a
// rotating pointer that only advances past grants downstream actually consumed.
module pen_rr_arb #(
   parameter int WIDTH = 8,
   parameter int N = 3,
   localparam int IW = $clog2(WIDTH),
   localparam int CW = $clog2(N + 1)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      rr_mode,
   input  logic [WIDTH-1:0]          req_vec,
   input  logic [CW-1:0]             accept_count,
   output logic [N-1:0]              ack_valid_by_n,
   output logic [N-1:0][WIDTH-1:0]   ack_one_hot_by_n,
   output logic [N-1:0][IW-1:0]      ack_index_by_n,
   output logic [CW-1:0]             ack_count,
   output logic [IW-1:0]             ptr
);

   logic [IW-1:0] ptr_next;

   // Walk requesters in scan order; the k-th set bit seen fills slot k.
   always_comb begin
      int base;
      int cnt;
      int pos;
      logic [IW-1:0] idx;
      ack_valid_by_n   = '0;
      ack_one_hot_by_n = '0;
      ack_index_by_n   = '0;
      base = rr_mode ? int'(ptr) : 0;
      cnt  = 0;
      pos  = 0;
      idx  = '0;
      if (!RST) begin
         for (int i = 0; i < WIDTH; i++) begin
            pos = base + i;
            if (pos >= WIDTH) pos = pos - WIDTH;
            idx = IW'(pos);
            if (req_vec[idx]) begin
               for (int n = 0; n < N; n++) begin
                  if (cnt == n) begin
                     ack_valid_by_n[n]        = 1'b1;
                     ack_one_hot_by_n[n][idx] = 1'b1;
                     ack_index_by_n[n]        = idx;
                  end
               end
               cnt = cnt + 1;
            end
         end
      end
      ack_count = CW'((cnt < N) ? cnt : N);
   end

   // Pointer moves just past the last consumed slot, so an unaccepted grant
   // becomes slot 0 on the following cycle.
   always_comb begin
      logic [CW-1:0] k_eff;
      logic [IW-1:0] last;
      k_eff = (accept_count < ack_count) ? accept_count : ack_count;
      last  = '0;
      for (int n = 0; n < N; n++) begin
         if (int'(k_eff) == n + 1) last = ack_index_by_n[n];
      end
      ptr_next = ptr;
      if (!rr_mode) begin
         ptr_next = '0;
      end else if (k_eff != '0) begin
         ptr_next = (int'(last) == WIDTH - 1) ? '0 : last + IW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) ptr <= '0;
      else     ptr <= ptr_next;
   end

endmodule

// File: tb/tb_pen_rr_arb.sv
// Scoreboard bench for pen_rr_arb: one 8-wide and one 6-wide instance share
// stimulus; a queue-based reference model predicts every cycle's outputs.
module tb_pen_rr_arb;

   typedef struct packed {
      logic [2:0]       valid;
      logic [2:0][7:0]  oh;
      logic [2:0][2:0]  idx;
      logic [1:0]       cnt;
      logic [2:0]       ptr;
      logic [2:0]       nptr;
   } exp_t;

   logic clk;
   logic rst;
   logic rr_mode;
   logic [7:0] req_vec;
   logic [1:0] accept_count;

   logic [2:0]       valid8;
   logic [2:0][7:0]  oh8;
   logic [2:0][2:0]  idx8;
   logic [1:0]       cnt8;
   logic [2:0]       ptr8;

   logic [2:0]       valid6;
   logic [2:0][5:0]  oh6;
   logic [2:0][2:0]  idx6;
   logic [1:0]       cnt6;
   logic [2:0]       ptr6;

   exp_t q8[$];
   exp_t q6[$];
   logic [2:0] mptr8;
   logic [2:0] mptr6;
   int n_cmp;
   int n_fail;

   pen_rr_arb #(.WIDTH(8), .N(3)) dut8 (
      .CLK(clk), .RST(rst), .rr_mode(rr_mode), .req_vec(req_vec),
      .accept_count(accept_count), .ack_valid_by_n(valid8),
      .ack_one_hot_by_n(oh8), .ack_index_by_n(idx8), .ack_count(cnt8),
      .ptr(ptr8)
   );

   pen_rr_arb #(.WIDTH(6), .N(3)) dut6 (
      .CLK(clk), .RST(rst), .rr_mode(rr_mode), .req_vec(req_vec[5:0]),
      .accept_count(accept_count), .ack_valid_by_n(valid6),
      .ack_one_hot_by_n(oh6), .ack_index_by_n(idx6), .ack_count(cnt6),
      .ptr(ptr6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: list the requesters in scan order, hand the first three out.
   function automatic exp_t model(input int w, input logic r, input logic mode,
                                  input logic [7:0] req, input logic [1:0] acc,
                                  input logic [2:0] p);
      exp_t e;
      int order[$];
      int base;
      int j;
      int cnt;
      int keff;
      e = '0;
      e.ptr = p;
      base = mode ? int'(p) : 0;
      for (int k = 0; k < w; k++) begin
         j = (base + k) % w;
         if (req[j[2:0]]) order.push_back(j);
      end
      if (r) return e;
      cnt = (order.size() < 3) ? order.size() : 3;
      for (int n = 0; n < cnt; n++) begin
         j = order[n];
         e.valid[n] = 1'b1;
         e.oh[n][j[2:0]] = 1'b1;
         e.idx[n] = j[2:0];
      end
      e.cnt = 2'(cnt);
      keff = (int'(acc) < cnt) ? int'(acc) : cnt;
      if (!mode)          e.nptr = 3'd0;
      else if (keff == 0) e.nptr = p;
      else                e.nptr = 3'((order[keff-1] + 1) % w);
      return e;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic mode,
                                 input logic [7:0] req, input logic [1:0] acc);
      exp_t e8;
      exp_t e6;
      @(posedge clk);
      #1;
      rst = r;
      rr_mode = mode;
      req_vec = req;
      accept_count = acc;
      e8 = model(8, r, mode, req, acc, mptr8);
      e6 = model(6, r, mode, {2'b00, req[5:0]}, acc, mptr6);
      q8.push_back(e8);
      q6.push_back(e6);
      mptr8 = r ? 3'd0 : e8.nptr;
      mptr6 = r ? 3'd0 : e6.nptr;
   endtask

   // Monitor: outputs are combinational, so each cycle's prediction is
   // compared mid-cycle on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (q8.size() > 0) begin
         e = q8.pop_front();
         check_output("valid8", 32'(valid8), 32'(e.valid));
         for (int n = 0; n < 3; n++) begin
            check_output($sformatf("onehot8[%0d]", n), 32'(oh8[n]), 32'(e.oh[n]));
            check_output($sformatf("index8[%0d]", n), 32'(idx8[n]), 32'(e.idx[n]));
         end
         check_output("count8", 32'(cnt8), 32'(e.cnt));
         check_output("ptr8", 32'(ptr8), 32'(e.ptr));
      end
      if (q6.size() > 0) begin
         e = q6.pop_front();
         check_output("valid6", 32'(valid6), 32'(e.valid));
         for (int n = 0; n < 3; n++) begin
            check_output($sformatf("onehot6[%0d]", n), 32'(oh6[n]), 32'(e.oh[n]));
            check_output($sformatf("index6[%0d]", n), 32'(idx6[n]), 32'(e.idx[n]));
         end
         check_output("count6", 32'(cnt6), 32'(e.cnt));
         check_output("ptr6", 32'(ptr6), 32'(e.ptr));
      end
   end

   // Steer the 8-wide pointer to p with a single accepted grant at p-1.
   task automatic set_ptr8(input int p);
      int b;
      logic [7:0] r;
      b = (p + 7) % 8;
      r = 8'd1 << b;
      apply_stimulus(1'b0, 1'b1, r, 2'd1);
   endtask

   initial begin
      int drain;
      n_cmp = 0;
      n_fail = 0;
      mptr8 = 3'd0;
      mptr6 = 3'd0;
      rst = 1'b1;
      rr_mode = 1'b1;
      req_vec = 8'hFF;
      accept_count = 2'd3;
      @(posedge clk);

      apply_stimulus(1'b1, 1'b1, 8'hFF, 2'd3);
      apply_stimulus(1'b0, 1'b1, 8'hFF, 2'd3);

      repeat (3) apply_stimulus(1'b0, 1'b0, 8'b01011010, 2'd3);

      repeat (3) apply_stimulus(1'b0, 1'b1, 8'hFF, 2'd3);

      apply_stimulus(1'b0, 1'b0, 8'h00, 2'd0);
      apply_stimulus(1'b0, 1'b1, 8'b10000011, 2'd1);
      apply_stimulus(1'b0, 1'b1, 8'b10000011, 2'd2);
      apply_stimulus(1'b0, 1'b1, 8'b10000011, 2'd0);
      apply_stimulus(1'b0, 1'b1, 8'b10000011, 2'd0);

      set_ptr8(3);
      apply_stimulus(1'b0, 1'b1, 8'b00100000, 2'd3);
      apply_stimulus(1'b0, 1'b1, 8'hFF, 2'd2);

      set_ptr8(5);
      apply_stimulus(1'b1, 1'b1, 8'hFF, 2'd3);
      apply_stimulus(1'b0, 1'b1, 8'hFF, 2'd3);

      for (int i = 0; i < 2000; i++) begin
         apply_stimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                        8'($urandom), 2'($urandom_range(0, 3)));
      end

      for (int m = 0; m < 2; m++) begin
         for (int p = 0; p < 8; p++) begin
            for (int r = 0; r < 256; r++) begin
               for (int a = 0; a < 4; a++) begin
                  set_ptr8(p);
                  apply_stimulus(1'b0, m[0], 8'(r), 2'(a));
               end
            end
         end
      end

      drain = 0;
      while ((q8.size() > 0 || q6.size() > 0) && drain < 5) begin
         @(posedge clk);
         drain = drain + 1;
      end
      if (q8.size() > 0 || q6.size() > 0) begin
         n_cmp = n_cmp + 1;
         n_fail = n_fail + 1;
         $display("[TB] FAIL drain: got %0d pending expected 0", q8.size() + q6.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
